// File: rtl/fpu_issue_ctrl.sv
// Generic show-ahead FIFO plus the fpu command-issue / result-collection stage.
// Issue latency: accept at edge N, issue at N+1 at the earliest, result visible after N+1+FPU_LAT.
// Backpressure: cmd_ready reflects only command-FIFO fullness; issue is credit-gated so the result FIFO never overflows.

// Show-ahead FIFO: head_dat is the oldest entry, cnt is the occupancy.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: push when full and pop when empty are ignored; callers gate both.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit, so their difference is the occupancy.
    assign cnt      = wr_ptr - rd_ptr;
    assign do_push  = push && !cnt[AW];
    assign do_pop   = pop && (cnt != '0);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// Buffers tagged fpu ops, drives the fpu operand registers, and returns results in issue order.
// Latency: accept->issue 1 edge, issue->result-FIFO push FPU_LAT edges (3 edges total at defaults).
// Backpressure: cmd_ready = !cmd_full; an op issues only while in-flight + stored results < DEPTH.
module fpu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int FPU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_op,
    input  logic [31:0]      fpu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [1:0]       res_op,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + FPU_LAT + 1);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       op;
    } res_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       op;
    } stage_t;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    cmd_t        cmd_in;
    cmd_t        cmd_head;
    logic [AW:0] cmd_cnt;
    logic        cmd_push;
    logic        cmd_empty;

    res_t        res_in;
    res_t        res_head;
    logic [AW:0] res_cnt;
    logic        res_push;
    logic        res_pop;
    logic        res_full;

    stage_t      stage [FPU_LAT];
    logic [CW-1:0] inflight_cnt;
    logic [CW-1:0] used_cnt;
    logic        credits_out;
    logic        issue;
    logic        drain_done;
    state_t      state;

    assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
    assign cmd_empty = (cmd_cnt == '0);
    assign cmd_ready = !cmd_cnt[AW];
    assign cmd_push  = cmd_valid && cmd_ready;

    sync_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cmd_push),
        .push_dat (cmd_in),
        .pop      (issue),
        .head_dat (cmd_head),
        .cnt      (cmd_cnt)
    );

    // Count ops currently travelling through the fpu pipeline.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < FPU_LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(stage[i].vld);
        end
    end

    // Every issued op owns a result slot from issue until its result is read.
    assign used_cnt    = inflight_cnt + CW'(res_cnt);
    assign credits_out = (used_cnt >= CW'(DEPTH));
    assign issue       = !cmd_empty && !credits_out;

    // Operand registers toward the fpu; they hold their value when nothing issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_a  <= '0;
            fpu_b  <= '0;
            fpu_op <= '0;
        end else if (issue) begin
            fpu_a  <= cmd_head.a;
            fpu_b  <= cmd_head.b;
            fpu_op <= cmd_head.op;
        end
    end

    // Tag/op tracker mirroring the fpu latency; clearing it drops pre-reset results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FPU_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{vld: issue, tag: cmd_head.tag, op: cmd_head.op};
            for (int i = 1; i < FPU_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign res_push = stage[FPU_LAT-1].vld;
    assign res_in   = '{data: fpu_result, tag: stage[FPU_LAT-1].tag, op: stage[FPU_LAT-1].op};
    assign res_full = res_cnt[AW];
    assign res_pop  = res_valid && res_ready;

    sync_fifo #(.W($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (res_push),
        .push_dat (res_in),
        .pop      (res_pop),
        .head_dat (res_head),
        .cnt      (res_cnt)
    );

    assign res_valid = (res_cnt != '0);
    assign res_data  = res_head.data;
    assign res_tag   = res_head.tag;
    assign res_op    = res_head.op;

    // Credits reserve a slot for every in-flight op, so a push into a full result FIFO is a logic bug.
    res_overflow_a: assert property (@(posedge clk) disable iff (rst) !(res_push && res_full));

    // Everything becomes empty at this edge: no queued or in-flight op, and the last result is leaving.
    assign drain_done = cmd_empty && (inflight_cnt == '0) && !cmd_push &&
                        ((res_cnt == '0) || ((res_cnt == (AW+1)'(1)) && res_pop));

    // Activity status: idle, running, or stalled waiting for a result to be read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (cmd_push) state <= RUN;
                RUN:     if (!cmd_empty && credits_out && !res_pop) state <= STALL;
                         else if (drain_done) state <= IDLE;
                STALL:   if (res_pop) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed and randomized bench for fpu_issue_ctrl with a queue-based reference model.
// A stand-in fpu (combinational, matching FPU_LAT=1) reproduces the known single-precision add exactly.
// Outputs are sampled 1 time unit after the rising edge; handshakes are captured just before it.
module tb_fpu_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int FPU_LAT = 1;
    localparam int TAG_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [1:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_op;
    logic [31:0]      fpu_result;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [1:0]       res_op;
    logic             busy;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.DEPTH(DEPTH), .FPU_LAT(FPU_LAT), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_op     (res_op),
        .busy       (busy)
    );

    // Stand-in fpu: the one known add returns its IEEE-754 sum, anything else a distinctive mix.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (op == 2'b01 && a == 32'h420151EC && b == 32'h4242147B) return 32'h42A1B333;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op} ^ 32'h5A5A_0000;
    endfunction

    always_comb fpu_result = fpu_fn(fpu_a, fpu_b, fpu_op);

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       op;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   accepted = 0;
    int   received = 0;
    int   n_acc;
    int   rx0;
    int   sent;
    logic last_acc;
    logic last_pop;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic load_cmd(input logic [TAG_W-1:0] tg);
        cmd_a   = $urandom;
        cmd_b   = $urandom;
        cmd_op  = 2'($urandom_range(0, 3));
        cmd_tag = tg;
    endtask

    // One clock: capture handshakes before the edge, then update the model after it.
    task automatic tick();
        logic             r;
        logic             acc;
        logic             pop;
        exp_t             seen;
        exp_t             want;
        exp_t             item;
        int               pre_size;
        #3;
        r    = rst;
        acc  = cmd_valid && cmd_ready;
        pop  = res_valid && res_ready;
        seen = '{data: res_data, tag: res_tag, op: res_op};
        item = '{data: fpu_fn(cmd_a, cmd_b, cmd_op), tag: cmd_tag, op: cmd_op};
        @(posedge clk);
        #1;
        last_acc = 1'b0;
        last_pop = 1'b0;
        if (r) begin
            exp_q.delete();
        end else begin
            pre_size = exp_q.size();
            if (acc) begin
                chk("accept_room", 64'(pre_size < 2*DEPTH), 64'd1);
            end
            if (pop) begin
                chk("res_q_nonempty", 64'(pre_size != 0), 64'd1);
                if (pre_size != 0) begin
                    want = exp_q.pop_front();
                    chk("res_data", seen.data, want.data);
                    chk("res_tag",  seen.tag,  want.tag);
                    chk("res_op",   seen.op,   want.op);
                end
                received++;
                last_pop = 1'b1;
            end
            if (acc) begin
                exp_q.push_back(item);
                accepted++;
                last_acc = 1'b1;
            end
        end
        chk("busy", busy, 64'(exp_q.size() != 0));
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_tag   = '0;

        // Reset for two cycles
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_fpu_a",     fpu_a,     0);
        chk("rst_fpu_b",     fpu_b,     0);
        chk("rst_fpu_op",    fpu_op,    0);
        chk("rst_res_data",  res_data,  0);
        chk("rst_res_tag",   res_tag,   0);
        chk("rst_res_op",    res_op,    0);
        rst = 1'b0;

        // Single add: result visible after the third edge counting the accepting one
        cmd_valid = 1'b1;
        cmd_a     = 32'h420151EC;
        cmd_b     = 32'h4242147B;
        cmd_op    = 2'b01;
        cmd_tag   = 4'd3;
        tick();
        chk("add_accept", last_acc, 1);
        cmd_valid = 1'b0;
        chk("add_res_valid_e1", res_valid, 0);
        tick();
        chk("add_fpu_a",  fpu_a,  32'h420151EC);
        chk("add_fpu_b",  fpu_b,  32'h4242147B);
        chk("add_fpu_op", fpu_op, 2'b01);
        chk("add_res_valid_e2", res_valid, 0);
        tick();
        chk("add_res_valid_e3", res_valid, 1);
        chk("add_res_data", res_data, 32'h42A1B333);
        chk("add_res_tag",  res_tag,  4'd3);
        chk("add_res_op",   res_op,   2'b01);
        res_ready = 1'b1;
        tick();
        chk("add_popped", last_pop, 1);
        res_ready = 1'b0;

        // Stall: results unread, ten commands offered, only 2*DEPTH fit
        n_acc = 0;
        load_cmd(TAG_W'(0));
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) begin
                n_acc++;
                if (n_acc < 10) load_cmd(TAG_W'(n_acc));
                else cmd_valid = 1'b0;
            end
        end
        chk("stall_accepts",   n_acc,     2*DEPTH);
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_busy",      busy,      1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        rx0 = received;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("stall_drained",  exp_q.size(),   0);
        chk("stall_received", received - rx0, 2*DEPTH);

        // Sustained throughput with the consumer always ready
        load_cmd(TAG_W'(5));
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("tput_cmd_ready", cmd_ready, 1);
            tick();
            if (last_acc) load_cmd(TAG_W'($urandom_range(0, 15)));
            chk("tput_res_valid", res_valid, 64'(i >= 2));
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("tput_drained", exp_q.size(), 0);

        // Reset with ops queued, in flight and unread
        res_ready = 1'b0;
        load_cmd(TAG_W'(7));
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (last_acc) load_cmd(TAG_W'(8 + i));
        end
        chk("mid_outstanding", exp_q.size(), 3);
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_busy",      busy,      0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_rst_no_res", res_valid, 0);
        end

        // Random gaps on both sides, tags wrap modulo 16, pointers wrap several times
        sent = 0;
        rx0  = received;
        load_cmd(TAG_W'(0));
        for (int i = 0; i < 400; i++) begin
            if (sent == 20 && exp_q.size() == 0) break;
            cmd_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_acc) begin
                sent++;
                if (sent < 20) load_cmd(TAG_W'(sent % 16));
            end
        end
        cmd_valid = 1'b0;
        chk("rand_sent",     sent,           20);
        chk("rand_drained",  exp_q.size(),   0);
        chk("rand_received", received - rx0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
